// File: rtl/ltc2992_pkg.sv
// Shared definitions for the LTC2992 poller: slave register map, control/flag
// bit positions, per-channel command table and the sequencer state encoding.
package ltc2992_pkg;

  // Slave register offsets
  localparam logic [3:0] AddrCr   = 4'd0;
  localparam logic [3:0] AddrFlag = 4'd2;
  localparam logic [3:0] AddrRx   = 4'd4;

  // CR bit positions
  localparam int unsigned CrCoreRstBit = 31;
  localparam int unsigned CrStartBit   = 30;
  localparam int unsigned CrCoreEnBit  = 29;
  localparam int unsigned CrRwBit      = 24;
  localparam int unsigned CrLenLsb     = 16;
  localparam int unsigned CrAddrLsb    = 8;

  // FLAG bit positions
  localparam int unsigned FlagDoneBit   = 0;
  localparam int unsigned FlagAckErrBit = 1;
  localparam int unsigned FlagBusyBit   = 2;

  // Each ADC result register is two bytes wide
  localparam logic [2:0] CrReadLen = 3'd2;

  localparam logic [31:0] FlagClrWord = 32'h0000_0001;

  typedef enum logic [3:0] {
    StIdle,
    StStart,
    StPoll,
    StEval,
    StClr,
    StRd,
    StEmit,
    StErr,
    StRst,
    StRstClr
  } state_e;

  // Register pointer for SENSE1, dSENSE1, SENSE2, dSENSE2
  function automatic logic [7:0] ch_cmd(logic [1:0] ch);
    logic [7:0] cmd;
    unique case (ch)
      2'd0:    cmd = 8'h28;
      2'd1:    cmd = 8'h14;
      2'd2:    cmd = 8'h5A;
      default: cmd = 8'h46;
    endcase
    return cmd;
  endfunction

  // Start + core_en + read, two bytes, from the given device and channel pointer
  function automatic logic [31:0] cr_start_word(logic [6:0] i2c_addr, logic [1:0] ch);
    logic [31:0] w;
    w = '0;
    w[CrStartBit]          = 1'b1;
    w[CrCoreEnBit]         = 1'b1;
    w[CrRwBit]             = 1'b1;
    w[CrLenLsb +: 3]       = CrReadLen;
    w[CrAddrLsb +: 7]      = i2c_addr;
    w[7:0]                 = ch_cmd(ch);
    return w;
  endfunction

  function automatic logic [15:0] sat_inc16(logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/ltc2992_poller_if.sv
// Avalon-MM style connection between the poller (master) and the LTC2992
// register block (slave). Strobes are active low; readdata is combinational.
interface ltc2992_poller_if;
  logic [3:0]  address;
  logic [31:0] writedata;
  logic        write_n;
  logic        read_n;
  logic [31:0] readdata;

  modport master (
    output address,
    output writedata,
    output write_n,
    output read_n,
    input  readdata
  );

  modport slave (
    input  address,
    input  writedata,
    input  write_n,
    input  read_n,
    output readdata
  );
endinterface

// File: rtl/ltc2992_tick_gen.sv
// Loadable down-counter that stops at zero; expired_o is high while it sits at zero.
module ltc2992_tick_gen #(
  parameter int unsigned Width = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic [Width-1:0] load_val_i,
  input  logic             en_i,
  output logic             expired_o
);

  logic [Width-1:0] count_q, count_d;

  // Load has priority over decrement; the count never wraps below zero
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (en_i && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  // Counter register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired_o = (count_q == '0);

endmodule

// File: rtl/ltc2992_poller.sv
// Round-robin reader of the four LTC2992 ADC result registers through the I2C
// register block. Emits tagged 12-bit samples; recovers and counts ack errors
// and timeouts without outside help.
module ltc2992_poller
  import ltc2992_pkg::*;
#(
  parameter int unsigned FREQ_CLK    = 100_000_000,
  parameter int unsigned POLL_PERIOD = 100_000,
  parameter int unsigned TIMEOUT_CYC = 50_000,
  parameter logic [6:0]  I2C_ADDR    = 7'h6F
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  ltc2992_poller_if.master         bus,
  output logic                     sample_valid,
  output logic [1:0]               sample_ch,
  output logic [11:0]              sample_data,
  output logic                     err_pulse,
  output logic [15:0]              err_cnt
);

  if ((POLL_PERIOD < 64) || (TIMEOUT_CYC == 0) || (FREQ_CLK == 0)) begin : g_param_check
    $error("ltc2992_poller: POLL_PERIOD must be >= 64, TIMEOUT_CYC and FREQ_CLK nonzero");
  end

  state_e      state_q, state_d;
  logic [1:0]  ch_q, ch_d;
  logic [2:0]  flag_q, flag_d;
  logic [11:0] sample_data_q, sample_data_d;
  logic [1:0]  sample_ch_q, sample_ch_d;
  logic [15:0] err_cnt_q, err_cnt_d;

  logic        per_expired, per_tick, per_load;
  logic [31:0] per_load_val;
  logic        to_load, to_expired;

  // Held at POLL_PERIOD while disabled so the first tick lands POLL_PERIOD cycles
  // after enable rises; reloading with POLL_PERIOD-1 on a tick keeps the spacing.
  assign per_tick     = enable && per_expired;
  assign per_load     = !enable || per_tick;
  assign per_load_val = enable ? 32'(POLL_PERIOD - 1) : 32'(POLL_PERIOD);

  ltc2992_tick_gen #(
    .Width (32)
  ) u_period (
    .clk        (clk),
    .reset      (reset),
    .load_i     (per_load),
    .load_val_i (per_load_val),
    .en_i       (enable),
    .expired_o  (per_expired)
  );

  // The START cycle itself counts as the first timeout cycle
  ltc2992_tick_gen #(
    .Width (32)
  ) u_timeout (
    .clk        (clk),
    .reset      (reset),
    .load_i     (to_load),
    .load_val_i (32'(TIMEOUT_CYC - 1)),
    .en_i       (1'b1),
    .expired_o  (to_expired)
  );

  // Sequencer next state, bus drive and output strobes
  always_comb begin
    state_d       = state_q;
    ch_d          = ch_q;
    flag_d        = flag_q;
    sample_data_d = sample_data_q;
    sample_ch_d   = sample_ch_q;
    err_cnt_d     = err_cnt_q;
    to_load       = 1'b0;
    bus.address   = '0;
    bus.writedata = '0;
    bus.write_n   = 1'b1;
    bus.read_n    = 1'b1;
    sample_valid  = 1'b0;
    err_pulse     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (per_tick) state_d = StStart;
      end
      StStart: begin
        bus.address   = AddrCr;
        bus.writedata = cr_start_word(I2C_ADDR, ch_q);
        bus.write_n   = 1'b0;
        to_load       = 1'b1;
        state_d       = StPoll;
      end
      StPoll: begin
        bus.address = AddrFlag;
        bus.read_n  = 1'b0;
        flag_d      = bus.readdata[2:0];
        state_d     = StEval;
      end
      StEval: begin
        // A completed transfer beats a timeout expiring in the same cycle
        if (flag_q[FlagDoneBit]) begin
          state_d = flag_q[FlagAckErrBit] ? StErr : StClr;
        end else if (to_expired) begin
          state_d = StRst;
        end else begin
          state_d = StPoll;
        end
      end
      StClr: begin
        bus.address   = AddrFlag;
        bus.writedata = FlagClrWord;
        bus.write_n   = 1'b0;
        state_d       = StRd;
      end
      StRd: begin
        bus.address   = AddrRx;
        bus.read_n    = 1'b0;
        sample_data_d = {bus.readdata[7:0], bus.readdata[15:12]};
        sample_ch_d   = ch_q;
        state_d       = StEmit;
      end
      StEmit: begin
        sample_valid = 1'b1;
        ch_d         = ch_q + 2'd1;
        state_d      = StIdle;
      end
      StErr: begin
        bus.address   = AddrFlag;
        bus.writedata = FlagClrWord;
        bus.write_n   = 1'b0;
        err_pulse     = 1'b1;
        err_cnt_d     = sat_inc16(err_cnt_q);
        ch_d          = ch_q + 2'd1;
        state_d       = StIdle;
      end
      StRst: begin
        bus.address              = AddrCr;
        bus.writedata            = '0;
        bus.writedata[CrCoreRstBit] = 1'b1;
        bus.write_n              = 1'b0;
        err_pulse                = 1'b1;
        err_cnt_d                = sat_inc16(err_cnt_q);
        state_d                  = StRstClr;
      end
      StRstClr: begin
        bus.address   = AddrFlag;
        bus.writedata = FlagClrWord;
        bus.write_n   = 1'b0;
        ch_d          = ch_q + 2'd1;
        state_d       = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Sequencer and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= StIdle;
      ch_q          <= 2'd0;
      flag_q        <= 3'd0;
      sample_data_q <= 12'd0;
      sample_ch_q   <= 2'd0;
      err_cnt_q     <= 16'd0;
    end else begin
      state_q       <= state_d;
      ch_q          <= ch_d;
      flag_q        <= flag_d;
      sample_data_q <= sample_data_d;
      sample_ch_q   <= sample_ch_d;
      err_cnt_q     <= err_cnt_d;
    end
  end

  assign sample_data = sample_data_q;
  assign sample_ch   = sample_ch_q;
  assign err_cnt     = err_cnt_q;

  // Busy flag is observed only through done; kept for the register map's completeness
  localparam int unsigned FlagBusyUnusedBit = FlagBusyBit;

endmodule

// File: tb/tb_ltc2992_poller.sv
// Scoreboard bench for ltc2992_poller: a slave model answers the bus, the
// stimulus queues expected bus writes / samples / error counts, and a monitor
// pops and compares them as the DUT produces them.
module tb_ltc2992_poller;

  localparam int unsigned PeriodA   = 256;
  localparam int unsigned DoneDelay = 200;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b1;
  logic        en_a  = 1'b0;
  logic        en_b  = 1'b0;
  int unsigned cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  ltc2992_poller_if bus_a ();
  ltc2992_poller_if bus_b ();

  logic        sv_a, ep_a, sv_b, ep_b;
  logic [1:0]  ch_a, ch_b;
  logic [11:0] data_a, data_b;
  logic [15:0] ec_a, ec_b;

  ltc2992_poller #(
    .POLL_PERIOD (PeriodA)
  ) u_dut_a (
    .clk          (clk),
    .reset        (reset),
    .enable       (en_a),
    .bus          (bus_a),
    .sample_valid (sv_a),
    .sample_ch    (ch_a),
    .sample_data  (data_a),
    .err_pulse    (ep_a),
    .err_cnt      (ec_a)
  );

  // Second instance with a short timeout; its slave never reports done
  ltc2992_poller #(
    .POLL_PERIOD (200),
    .TIMEOUT_CYC (100)
  ) u_dut_b (
    .clk          (clk),
    .reset        (reset),
    .enable       (en_b),
    .bus          (bus_b),
    .sample_valid (sv_b),
    .sample_ch    (ch_b),
    .sample_data  (data_b),
    .err_pulse    (ep_b),
    .err_cnt      (ec_b)
  );

  assign bus_b.readdata = '0;

  // Slave model for instance A: done rises DoneDelay cycles after a start write
  logic        act_a = 1'b0, done_a = 1'b0, ack_cfg = 1'b0;
  logic [31:0] rx_cfg = '0;
  int unsigned done_at_a = 0, done_set_cyc = 0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      act_a  <= 1'b0;
      done_a <= 1'b0;
    end else if (!bus_a.write_n) begin
      if (bus_a.address == 4'd0 && bus_a.writedata[30]) begin
        act_a     <= 1'b1;
        done_a    <= 1'b0;
        done_at_a <= cyc + DoneDelay;
      end else if (bus_a.address == 4'd0 && bus_a.writedata[31]) begin
        act_a  <= 1'b0;
        done_a <= 1'b0;
      end else if (bus_a.address == 4'd2 && bus_a.writedata[0]) begin
        act_a  <= 1'b0;
        done_a <= 1'b0;
      end
    end else if (act_a && !done_a && cyc >= done_at_a) begin
      done_a       <= 1'b1;
      done_set_cyc <= cyc + 1;
    end
  end

  always_comb begin
    bus_a.readdata = '0;
    if (!bus_a.read_n) begin
      case (bus_a.address)
        4'd2:    bus_a.readdata = {29'd0, act_a && !done_a, done_a && ack_cfg, done_a};
        4'd4:    bus_a.readdata = rx_cfg;
        default: bus_a.readdata = '0;
      endcase
    end
  end

  // Scoreboard
  typedef enum logic [1:0] {EvWrite, EvSample, EvErr} ev_kind_e;
  typedef struct {
    ev_kind_e    kind;
    logic [3:0]  addr;
    logic [31:0] data;
  } ev_t;

  ev_t exp_q[$];
  int  checks = 0;
  int  errors = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h (t=%0t)", name, act, req, $time);
    end
  endfunction

  function automatic void push(ev_kind_e k, logic [3:0] a, logic [31:0] d);
    ev_t e;
    e.kind = k;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endfunction

  function automatic void check_ev(ev_kind_e k, logic [3:0] a, logic [31:0] d, string name);
    ev_t e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s unexpected: got addr %h data %h, required no event", name, a, d);
      return;
    end
    e = exp_q.pop_front();
    chk({name, "_kind"}, 32'(k), 32'(e.kind));
    chk({name, "_addr"}, {28'd0, a}, {28'd0, e.addr});
    chk({name, "_data"}, d, e.data);
  endfunction

  // Monitor: compares every DUT output event against the queue head
  logic err_pend = 1'b0;
  initial forever begin
    @(negedge clk);
    if (reset) begin
      err_pend = 1'b0;
    end else begin
      if (err_pend) begin
        check_ev(EvErr, 4'd0, {16'd0, ec_a}, "err_cnt");
        err_pend = 1'b0;
      end
      chk("bus_exclusive", {31'd0, !bus_a.write_n && !bus_a.read_n}, 32'd0);
      if (bus_a.write_n && bus_a.read_n)
        chk("idle_bus", {28'd0, bus_a.address} | bus_a.writedata, 32'd0);
      if (!bus_a.write_n) check_ev(EvWrite, bus_a.address, bus_a.writedata, "write");
      if (sv_a) begin
        check_ev(EvSample, {2'd0, ch_a}, {20'd0, data_a}, "sample");
        chk("done_to_valid_le6", 32'((cyc - done_set_cyc) <= 6), 32'd1);
      end
      if (ep_a) err_pend = 1'b1;
    end
  end

  task automatic wait_empty(string name, int unsigned max_cyc);
    int unsigned n = 0;
    while (exp_q.size() != 0 && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_drained"}, exp_q.size(), 32'd0);
    exp_q.delete();
  endtask

  // Expected read transaction: CR start, FLAG clear, tagged sample
  function automatic void exp_read(logic [31:0] cr, logic [1:0] ch, logic [11:0] smp);
    push(EvWrite, 4'd0, cr);
    push(EvWrite, 4'd2, 32'h1);
    push(EvSample, {2'd0, ch}, {20'd0, smp});
  endfunction

  logic [31:0] rr_cr  [4] = '{32'h6102_6F14, 32'h6102_6F5A, 32'h6102_6F46, 32'h6102_6F28};
  logic [31:0] rr_rx  [4] = '{32'h0000_1234, 32'h0000_FFF0, 32'h0000_0081, 32'h0000_7E00};
  logic [11:0] rr_smp [4] = '{12'h341, 12'hF0F, 12'h810, 12'h007};

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  initial begin
    int unsigned n, t0, ncr;
    logic        found;

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_write_n", {31'd0, bus_a.write_n}, 32'd1);
    chk("rst_read_n", {31'd0, bus_a.read_n}, 32'd1);
    chk("rst_addr_wdata", {28'd0, bus_a.address} | bus_a.writedata, 32'd0);
    chk("rst_sample", {17'd0, sv_a, ch_a, data_a}, 32'd0);
    chk("rst_err", {15'd0, ep_a, ec_a}, 32'd0);
    chk("rst_b_outputs", {sv_b, ch_b, data_b, ep_b, ec_b}, 32'd0);
    reset = 1'b0;

    // Timeout on instance B
    en_b  = 1'b1;
    n     = 0;
    found = 1'b0;
    while (!found && n < 400) begin
      @(negedge clk);
      n++;
      if (!bus_b.write_n && bus_b.address == 4'd0) found = 1'b1;
    end
    chk("b_start_seen", {31'd0, found}, 32'd1);
    chk("b_start_word", bus_b.writedata, 32'h6102_6F28);
    t0    = cyc;
    n     = 0;
    found = 1'b0;
    while (!found && n < 200) begin
      @(negedge clk);
      n++;
      if (!bus_b.write_n) found = 1'b1;
    end
    chk("b_rst_seen", {31'd0, found}, 32'd1);
    chk("b_rst_addr", {28'd0, bus_b.address}, 32'd0);
    chk("b_rst_word", bus_b.writedata, 32'h8000_0000);
    chk("b_rst_within_102", 32'((cyc - t0) <= 102), 32'd1);
    chk("b_err_pulse", {31'd0, ep_b}, 32'd1);
    @(negedge clk);
    chk("b_err_cnt", {16'd0, ec_b}, 32'd1);
    chk("b_flag_clr", {bus_b.write_n, 27'd0, bus_b.address} | bus_b.writedata, 32'h3);
    chk("b_no_sample", {31'd0, sv_b}, 32'd0);
    en_b = 1'b0;

    // Nominal read of channel 0
    rx_cfg = 32'h0000_A5C0;
    exp_read(32'h6102_6F28, 2'd0, 12'hC0A);
    en_a = 1'b1;
    wait_empty("nominal", 1000);

    // Round robin through channels 1, 2, 3 and back to 0
    for (int i = 0; i < 4; i++) begin
      rx_cfg = rr_rx[i];
      exp_read(rr_cr[i], 2'(i + 1), rr_smp[i]);
      wait_empty("round_robin", 600);
    end

    // Enable drops mid-read: sample still emitted, then silence
    rx_cfg = 32'h0000_3C90;
    exp_read(32'h6102_6F14, 2'd1, 12'h903);
    n = 0;
    while (!act_a && n < 600) begin
      @(negedge clk);
      n++;
    end
    chk("disable_txn_started", {31'd0, act_a}, 32'd1);
    en_a = 1'b0;
    wait_empty("disable_midread", 600);
    ncr = 0;
    for (int i = 0; i < 3 * PeriodA; i++) begin
      @(negedge clk);
      if (!bus_a.write_n && bus_a.address == 4'd0) ncr++;
    end
    chk("no_cr_after_disable", ncr, 32'd0);

    // Asynchronous reset while polling FLAG
    en_a = 1'b1;
    push(EvWrite, 4'd0, 32'h6102_6F5A);
    n     = 0;
    found = 1'b0;
    while (!found && n < 700) begin
      @(negedge clk);
      n++;
      if (!bus_a.read_n && bus_a.address == 4'd2) found = 1'b1;
    end
    chk("poll_seen", {31'd0, found}, 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("arst_read_n", {31'd0, bus_a.read_n}, 32'd1);
    chk("arst_write_n", {31'd0, bus_a.write_n}, 32'd1);
    chk("arst_addr_wdata", {28'd0, bus_a.address} | bus_a.writedata, 32'd0);
    chk("arst_sample", {17'd0, sv_a, ch_a, data_a}, 32'd0);
    chk("arst_err", {15'd0, ep_a, ec_a}, 32'd0);
    chk("arst_queue", exp_q.size(), 32'd0);
    exp_q.delete();
    repeat (2) @(negedge clk);

    // First transaction after reset hits an ack error on channel 0
    ack_cfg = 1'b1;
    push(EvWrite, 4'd0, 32'h6102_6F28);
    push(EvWrite, 4'd2, 32'h1);
    push(EvErr, 4'd0, 32'd1);
    reset = 1'b0;
    wait_empty("ack_error", 600);

    // No sample for the errored read; next read moves on to channel 1
    ack_cfg = 1'b0;
    rx_cfg  = 32'h0000_0F5A;
    exp_read(32'h6102_6F14, 2'd1, 12'h5A0);
    wait_empty("after_ack_error", 1000);

    en_a = 1'b0;
    repeat (4) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
